// File: rtl/flitzip_pkg.sv
// flitzip_pkg: shared constants, decoder state and helpers
// for the flit decompressor.
package flitzip_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int CHUNK_SIZE = 8;
    localparam int EN_BITS    = 3;
    localparam int LANES      = 4;

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_SIZE;
    localparam int STEPS      = NUM_CHUNKS / LANES;
    localparam int IDX_W      = $clog2(NUM_CHUNKS);
    localparam int CNT_W      = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int DW_W       = $clog2(CHUNK_SIZE + 1);
    localparam int SB_W       = $clog2(CHUNK_SIZE);
    localparam int SH_W       = $clog2(DATA_WIDTH);

    localparam logic [EN_BITS-1:0] RAW_CODE = '1;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } dec_state_e;

    // Delta width for an encoding code, capped at one chunk.
    function automatic logic [DW_W-1:0] delta_width(
        input logic [EN_BITS-1:0] en
    );
        logic [DW_W-1:0] w;
        w = DW_W'(en) + DW_W'(2);
        return (w > DW_W'(CHUNK_SIZE)) ? DW_W'(CHUNK_SIZE) : w;
    endfunction

endpackage

// File: rtl/flitzip_delta_lane.sv
// flitzip_delta_lane: rebuilds one chunk from base + signed delta.
// FLITZIP_DECOMP_ERR_CHK_EN adds the ovf_o unwrapped-range flag.
module flitzip_delta_lane
    import flitzip_pkg::*;
(
    input  logic [CHUNK_SIZE-1:0] base_i,
    input  logic [EN_BITS-1:0]    en_i,
    input  logic [DATA_WIDTH-1:0] payload_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [CHUNK_SIZE-1:0] chunk_o
`ifdef FLITZIP_DECOMP_ERR_CHK_EN
    ,
    output logic                  ovf_o
`endif
);

    logic [DW_W-1:0]       dw;
    logic [SH_W-1:0]       shamt;
    logic [SB_W-1:0]       sb;
    logic [CHUNK_SIZE-1:0] field;
    logic [CHUNK_SIZE-1:0] mask;
    logic [CHUNK_SIZE-1:0] delta;

    // Extract the packed field and sign-extend it to a full chunk.
    always_comb begin
        dw    = delta_width(en_i);
        shamt = SH_W'(idx_i) * SH_W'(dw);
        field = CHUNK_SIZE'(payload_i >> shamt);
        mask  = {CHUNK_SIZE{1'b1}} >> (DW_W'(CHUNK_SIZE) - dw);
        sb    = SB_W'(dw - DW_W'(1));
        delta = field[sb] ? (field | ~mask) : (field & mask);
    end

`ifdef FLITZIP_DECOMP_ERR_CHK_EN
    logic [CHUNK_SIZE+1:0] sum;

    // Two extra bits keep the true sum; either one set means out of range.
    always_comb begin
        sum = {2'b00, base_i}
            + {{2{delta[CHUNK_SIZE-1]}}, delta};
        chunk_o = sum[CHUNK_SIZE-1:0];
        ovf_o   = sum[CHUNK_SIZE+1] | sum[CHUNK_SIZE];
    end
`else
    // Result wraps modulo 2^CHUNK_SIZE.
    always_comb begin
        chunk_o = base_i + delta;
    end
`endif

endmodule

// File: rtl/flit_decompressor.sv
// flit_decompressor: rebuilds a 128-bit flit from base/en/deltas.
// FLITZIP_DECOMP_ERR_CHK_EN enables the sticky err_out overflow flag.
module flit_decompressor
    import flitzip_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHUNK_SIZE-1:0] in_base,
    input  logic [EN_BITS-1:0]    in_en,
    input  logic [DATA_WIDTH-1:0] in_payload,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_raw,
    output logic                  err_out
);

    dec_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CHUNK_SIZE-1:0] base_q;
    logic [EN_BITS-1:0]    en_q;
    logic [DATA_WIDTH-1:0] payload_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  out_raw_q;

    logic [CHUNK_SIZE-1:0] lane_chunk [LANES];
    logic [IDX_W-1:0]      lane_idx   [LANES];

`ifdef FLITZIP_DECOMP_ERR_CHK_EN
    logic [LANES-1:0]      lane_ovf;
    logic                  err_q;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = IDX_W'(cnt_q) * IDX_W'(LANES)
                           + IDX_W'(l);

        flitzip_delta_lane u_lane (
            .base_i    (base_q),
            .en_i      (en_q),
            .payload_i (payload_q),
            .idx_i     (lane_idx[l]),
            .chunk_o   (lane_chunk[l])
`ifdef FLITZIP_DECOMP_ERR_CHK_EN
            ,
            .ovf_o     (lane_ovf[l])
`endif
        );
    end

    // Accept, decode LANES chunks per cycle, then present and hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            en_q        <= '0;
            payload_q   <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_raw_q   <= 1'b0;
`ifdef FLITZIP_DECOMP_ERR_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        base_q     <= in_base;
                        en_q       <= in_en;
                        payload_q  <= in_payload;
                        if (in_en == RAW_CODE) begin
                            data_q    <= in_payload;
                            out_raw_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            cnt_q     <= '0;
                            out_raw_q <= 1'b0;
                            state_q   <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    for (int l = 0; l < LANES; l++) begin
                        data_q[int'(lane_idx[l])*CHUNK_SIZE +: CHUNK_SIZE]
                            <= lane_chunk[l];
                    end
`ifdef FLITZIP_DECOMP_ERR_CHK_EN
                    err_q <= err_q | (|lane_ovf);
`endif
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_raw   = out_raw_q;

`ifdef FLITZIP_DECOMP_ERR_CHK_EN
    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_flit_decompressor.sv
// tb_flit_decompressor: directed and random flits against
// a chunk-level arithmetic model of the decompression rules.
module tb_flit_decompressor;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_base = '0;
    logic [2:0]   in_en = '0;
    logic [127:0] in_payload = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_raw;
    logic         err_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    flit_decompressor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_en      (in_en),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_raw    (out_raw),
        .err_out    (err_out)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flit reconstruction straight from the arithmetic definition.
    function automatic void model(input logic [7:0] b,
                                  input logic [2:0] e,
                                  input logic [127:0] p,
                                  output logic [127:0] d,
                                  output logic ovf);
        int w, v, s;
        logic [127:0] one;
        one = 128'd1;
        d   = '0;
        ovf = 1'b0;
        if (e == 3'b111) begin
            d = p;
            return;
        end
        w = (int'(e) + 2 > 8) ? 8 : int'(e) + 2;
        for (int i = 0; i < 16; i++) begin
            v = int'((p >> (i * w)) & ((one << w) - one));
            if (v >= (1 << (w - 1))) v -= (1 << w);
            s = int'(b) + v;
            d[i*8 +: 8] = 8'(s & 255);
            if (s < 0 || s > 255) ovf = 1'b1;
        end
    endfunction

    // Present a flit until accepted; returns once the accept edge passed.
    task automatic offer(input logic [7:0] b, input logic [2:0] e,
                         input logic [127:0] p, output bit ok);
        int w;
        in_base    = b;
        in_en      = e;
        in_payload = p;
        in_valid   = 1'b1;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        ok = in_ready;
        chk("accept_wait", in_ready, 1);
        if (ok) tick();
        in_valid   = 1'b0;
        in_base    = 8'($urandom);
        in_en      = 3'($urandom);
        in_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_flit(input logic [7:0] b, input logic [2:0] e,
                            input logic [127:0] p, input int bp);
        logic [127:0] exp_d;
        logic         ovf;
        bit           ok;
        int           lat;
        model(b, e, p, exp_d, ovf);
        out_ready = 1'b0;
        offer(b, e, p, ok);
        if (!ok) return;
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        chk("latency", lat, (e == 3'b111) ? 1 : 5);
`ifdef FLITZIP_DECOMP_ERR_CHK_EN
        if (e != 3'b111 && ovf) exp_err = 1'b1;
`endif
        chk("data", out_data, exp_d);
        chk("raw", out_raw, (e == 3'b111));
        chk("err", err_out, exp_err);
        for (int i = 0; i < bp; i++) begin
            chk("in_ready_done", in_ready, 0);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp_d);
            chk("hold_raw", out_raw, (e == 3'b111));
        end
        chk("in_ready_done", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        bit ok;
        logic [127:0] pay;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_raw", out_raw, 0);
        chk("rst_err", err_out, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", in_ready, 1);

        run_flit(8'h80, 3'd0, {32{4'h5}}, 0);
        run_flit(8'h00, 3'd6, {128{1'b1}}, 1);
        run_flit(8'h5a, 3'b111,
                 128'h0123456789ABCDEF_FEDCBA9876543210, 0);
        run_flit(8'h3c, 3'd1, {$urandom, $urandom, $urandom, $urandom},
                 10);
        run_flit(8'h10, 3'd2, {64'h0, 64'h8787_8787_8787_8787}, 2);
        run_flit(8'hff, 3'd3, {32{4'h1}}, 0);

        pay = {$urandom, $urandom, $urandom, $urandom};
        offer(8'h20, 3'd4, pay, ok);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        exp_err = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_err", err_out, 0);
        chk("midrst_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_rel", in_ready, 1);
        run_flit(8'h10, 3'd2, {64'h0, 64'h8787_8787_8787_8787}, 0);

        for (int k = 0; k < 40; k++) begin
            run_flit(8'($urandom), 3'($urandom_range(0, 7)),
                     {$urandom, $urandom, $urandom, $urandom},
                     $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
